// File: rtl/serv_alu_seq_pkg.sv
// Shared op-class codes and sequencer state encoding for the bit-serial ALU sequencer.
package serv_alu_seq_pkg;

  typedef enum logic [1:0] {
    OP_ARITH = 2'd0,
    OP_SLT   = 2'd1,
    OP_SHIFT = 2'd2,
    OP_CMP   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_GAP  = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Shift amounts are 5 bits wide, loaded during the first cycles of INIT.
  localparam int SHAMT_BITS = 5;

endpackage

// File: rtl/serv_alu_seq_bitcnt.sv
// Bit counter for the serial ALU phases: clear has priority, wraps to 0 after WIDTH-1.
module serv_alu_seq_bitcnt #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [CW-1:0] o_cnt,
  output logic          o_last
);

  assign o_last = (o_cnt == CW'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cnt <= '0;
    end else if (i_clr) begin
      o_cnt <= '0;
    end else if (i_en) begin
      o_cnt <= o_last ? '0 : o_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serv_alu_seq.sv
// Phase sequencer for the bit-serial ALU: INIT -> GAP -> RUN ordering and all ALU strobes.
module serv_alu_seq
  import serv_alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [1:0]    i_op,
  input  logic          i_flush,
  output logic          o_ready,
  output logic          o_en,
  output logic          o_init,
  output logic          o_shamt_en,
  output logic          o_cnt_done,
  output logic          o_rd_en,
  output logic          o_cmp_vld,
  output logic          o_done,
  output logic [CW-1:0] o_cnt
);

  state_e        state_q, state_d;
  op_e           op_q;
  logic          accept;
  logic          cnt_en;
  logic          cnt_last;

  // Flush beats start in IDLE, and freezes the counter at 0 on its way out of a phase.
  assign accept = (state_q == ST_IDLE) && i_start && !i_flush;
  assign cnt_en = ((state_q == ST_INIT) || (state_q == ST_RUN)) && !i_flush;

  serv_alu_seq_bitcnt #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bitcnt (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_clr   (!cnt_en),
    .i_en    (cnt_en),
    .o_cnt   (o_cnt),
    .o_last  (cnt_last)
  );

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ARITH;
    end else begin
      state_q <= state_d;
      if (accept) op_q <= op_e'(i_op);
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = (op_e'(i_op) == OP_ARITH) ? ST_RUN : ST_INIT;
      ST_INIT: if (cnt_last) state_d = (op_q == OP_CMP) ? ST_DONE : ST_GAP;
      ST_GAP:  state_d = ST_RUN;
      ST_RUN:  if (cnt_last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (i_flush) state_d = ST_IDLE;
  end

  // Strobes depend only on registered state, op and count; GAP leaves everything low.
  always_comb begin
    o_ready    = 1'b0;
    o_en       = 1'b0;
    o_init     = 1'b0;
    o_shamt_en = 1'b0;
    o_cnt_done = 1'b0;
    o_rd_en    = 1'b0;
    o_cmp_vld  = 1'b0;
    o_done     = 1'b0;
    case (state_q)
      ST_IDLE: o_ready = 1'b1;
      ST_INIT: begin
        o_en       = 1'b1;
        o_init     = 1'b1;
        o_shamt_en = (op_q == OP_SHIFT) && (o_cnt < CW'(SHAMT_BITS));
        o_cnt_done = cnt_last;
        o_cmp_vld  = cnt_last && (op_q == OP_CMP);
      end
      ST_RUN: begin
        o_en       = 1'b1;
        o_rd_en    = 1'b1;
        o_cnt_done = cnt_last;
      end
      ST_DONE: o_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_serv_alu_seq.sv
// Self-checking bench for serv_alu_seq: directed phase scenarios plus randomized ops vs a cycle-table model.
module tb_serv_alu_seq;
  import serv_alu_seq_pkg::*;

  localparam int W  = 32;
  localparam int CW = 5;
  localparam logic [12:0] IDLE_VEC = 13'b1_0000000_00000;

  logic          clk = 1'b0;
  logic          i_rst_n;
  logic          i_start;
  logic [1:0]    i_op;
  logic          i_flush;
  logic          o_ready, o_en, o_init, o_shamt_en, o_cnt_done, o_rd_en, o_cmp_vld, o_done;
  logic [CW-1:0] o_cnt;
  logic [12:0]   obs;

  int checks = 0;
  int errors = 0;

  serv_alu_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_op       (i_op),
    .i_flush    (i_flush),
    .o_ready    (o_ready),
    .o_en       (o_en),
    .o_init     (o_init),
    .o_shamt_en (o_shamt_en),
    .o_cnt_done (o_cnt_done),
    .o_rd_en    (o_rd_en),
    .o_cmp_vld  (o_cmp_vld),
    .o_done     (o_done),
    .o_cnt      (o_cnt)
  );

  always #5 clk = ~clk;

  // Observed vector: {ready, en, init, shamt_en, cnt_done, rd_en, cmp_vld, done, cnt}
  assign obs = {o_ready, o_en, o_init, o_shamt_en, o_cnt_done, o_rd_en, o_cmp_vld, o_done, o_cnt};

  // Reference: expected outputs on cycle k after the accept edge (k=1 is the first strobe cycle).
  function automatic logic [12:0] exp_vec(op_e op, int k);
    logic rdy, en, ini, sh, cd, rd, cv, dn;
    int   c;
    {rdy, en, ini, sh, cd, rd, cv, dn} = 8'b0;
    c = 0;
    if (op == OP_ARITH) begin
      if (k <= W) begin
        en = 1; rd = 1; c = k - 1; cd = (k == W);
      end else if (k == W + 1) dn = 1;
      else rdy = 1;
    end else if (k <= W) begin
      en = 1; ini = 1; c = k - 1; cd = (k == W);
      sh = (op == OP_SHIFT) && (k <= 5);
      cv = (op == OP_CMP) && (k == W);
    end else if (op == OP_CMP) begin
      if (k == W + 1) dn = 1;
      else rdy = 1;
    end else if (k == W + 1) begin
      // gap cycle: everything low
    end else if (k <= 2 * W + 1) begin
      en = 1; rd = 1; c = k - W - 2; cd = (k == 2 * W + 1);
    end else if (k == 2 * W + 2) dn = 1;
    else rdy = 1;
    return {rdy, en, ini, sh, cd, rd, cv, dn, CW'(c)};
  endfunction

  function automatic int op_len(op_e op);
    return (op == OP_ARITH || op == OP_CMP) ? W + 1 : 2 * W + 2;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input op_e op);
    i_op    = op;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0; i_start = 1'b0; i_flush = 1'b0; i_op = 2'd0;
    #3;
    checks++;
    if (obs !== IDLE_VEC) begin
      errors++; $display("FAIL reset_state got=%b exp=%b", obs, IDLE_VEC);
    end
    tick(); tick();
    i_rst_n = 1'b1;
    tick();
    checks++;
    if (obs !== IDLE_VEC) begin
      errors++; $display("FAIL reset_release got=%b exp=%b", obs, IDLE_VEC);
    end
  endtask

  task automatic test_reset_mid_run;
    int rd_cnt, dn_cnt;
    start_op(OP_ARITH);
    repeat (17) tick();
    checks++;
    if (o_cnt !== 5'd17 || o_rd_en !== 1'b1) begin
      errors++; $display("FAIL mid_run_cnt got=%0d rd=%b exp=17 rd=1", o_cnt, o_rd_en);
    end
    #2;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== IDLE_VEC) begin
      errors++; $display("FAIL reset_mid_run got=%b exp=%b", obs, IDLE_VEC);
    end
    tick();
    i_rst_n = 1'b1;
    tick();
    rd_cnt = 0; dn_cnt = 0;
    start_op(OP_ARITH);
    for (int k = 1; k <= 40; k++) begin
      rd_cnt += int'(o_rd_en);
      dn_cnt += int'(o_done);
      tick();
    end
    checks++;
    if (rd_cnt != 32 || dn_cnt != 1) begin
      errors++; $display("FAIL post_reset_arith rd_en=%0d done=%0d exp rd_en=32 done=1", rd_cnt, dn_cnt);
    end
  endtask

  task automatic test_arith;
    start_op(OP_ARITH);
    for (int k = 1; k <= op_len(OP_ARITH) + 1; k++) begin
      checks++;
      if (obs !== exp_vec(OP_ARITH, k)) begin
        errors++; $display("FAIL arith cyc=%0d got=%b exp=%b", k, obs, exp_vec(OP_ARITH, k));
      end
      if (k <= op_len(OP_ARITH)) tick();
    end
  endtask

  task automatic test_shift;
    start_op(OP_SHIFT);
    for (int k = 1; k <= op_len(OP_SHIFT) + 1; k++) begin
      checks++;
      if (obs !== exp_vec(OP_SHIFT, k)) begin
        errors++; $display("FAIL shift cyc=%0d got=%b exp=%b", k, obs, exp_vec(OP_SHIFT, k));
      end
      if (k <= op_len(OP_SHIFT)) tick();
    end
  endtask

  task automatic test_cmp;
    start_op(OP_CMP);
    for (int k = 1; k <= op_len(OP_CMP) + 1; k++) begin
      checks++;
      if (obs !== exp_vec(OP_CMP, k)) begin
        errors++; $display("FAIL cmp cyc=%0d got=%b exp=%b", k, obs, exp_vec(OP_CMP, k));
      end
      if (k <= op_len(OP_CMP)) tick();
    end
  endtask

  task automatic test_back_to_back;
    i_op    = OP_SLT;
    i_start = 1'b1;
    tick();
    for (int k = 1; k <= op_len(OP_SLT) + 1; k++) begin
      checks++;
      if (obs !== exp_vec(OP_SLT, k)) begin
        errors++; $display("FAIL b2b_slt cyc=%0d got=%b exp=%b", k, obs, exp_vec(OP_SLT, k));
      end
      tick();
    end
    checks++;
    if (obs !== exp_vec(OP_SLT, 1)) begin
      errors++; $display("FAIL b2b_second_accept got=%b exp=%b", obs, exp_vec(OP_SLT, 1));
    end
    i_start = 1'b0;
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    checks++;
    if (obs !== IDLE_VEC) begin
      errors++; $display("FAIL b2b_flush got=%b exp=%b", obs, IDLE_VEC);
    end
  endtask

  task automatic test_flush;
    start_op(OP_SHIFT);
    repeat (9) tick();
    checks++;
    if (obs !== exp_vec(OP_SHIFT, 10)) begin
      errors++; $display("FAIL flush_pre cyc=10 got=%b exp=%b", obs, exp_vec(OP_SHIFT, 10));
    end
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    for (int k = 11; k <= 80; k++) begin
      checks++;
      if (obs !== IDLE_VEC) begin
        errors++; $display("FAIL flush_idle cyc=%0d got=%b exp=%b", k, obs, IDLE_VEC);
      end
      tick();
    end
    i_op    = OP_ARITH;
    i_start = 1'b1;
    i_flush = 1'b1;
    tick();
    i_start = 1'b0;
    i_flush = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (obs !== IDLE_VEC) begin
        errors++; $display("FAIL flush_start cyc=%0d got=%b exp=%b", k, obs, IDLE_VEC);
      end
      tick();
    end
  endtask

  // Random ops with i_op/i_start noise while busy and occasional mid-op flushes.
  task automatic test_random;
    op_e op;
    int  len, fk;
    for (int n = 0; n < 40; n++) begin
      op  = op_e'($urandom_range(0, 3));
      len = op_len(op);
      fk  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, len - 1)) : 0;
      start_op(op);
      for (int k = 1; k <= len + 1; k++) begin
        logic [12:0] e;
        e = (fk != 0 && k > fk) ? IDLE_VEC : exp_vec(op, k);
        checks++;
        if (obs !== e) begin
          errors++; $display("FAIL random n=%0d op=%0d cyc=%0d got=%b exp=%b", n, op, k, obs, e);
        end
        if (fk != 0 && k > fk) break;
        if (k <= len) begin
          i_op    = 2'($urandom_range(0, 3));
          i_start = 1'($urandom_range(0, 1));
          i_flush = (k == fk);
          tick();
          i_start = 1'b0;
          i_flush = 1'b0;
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_run();
    test_arith();
    test_shift();
    test_cmp();
    test_back_to_back();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
